// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed dual-channel FIR controller.
// One registered multiplier is shared across all taps of both channels, and
// each channel has its own accumulator. A packet stores L/R samples into a
// circular history and latches the filter selection. The block then walks the
// coefficient ROM and the history, and presents scaled, saturated results.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   sw              one-hot filter-select switches (anything else selects bypass)
//   new_packet      strobe qualifying in_l / in_r
//   in_l, in_r      signed input samples
//   coef_addr       coefficient ROM address (data returns one cycle later)
//   coef_data       signed Q1.15 coefficient from ROM
//   out_l, out_r    filtered samples, updated with out_valid
//   out_valid       one-cycle result strobe
//   busy            packet in progress (accept .. out_valid)
//   selected_filter filter latched at accept, 0 = bypass
//   overrun_cnt     saturating count of dropped packets
module fir_mac_scheduler #(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned COEFF_WIDTH = 16,
  parameter int unsigned N_TAPS      = 45,
  parameter int unsigned N_FILTERS   = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [N_FILTERS-1:0]                  sw,
  input  logic                                  new_packet,
  input  logic [DATA_WIDTH-1:0]                 in_l,
  input  logic [DATA_WIDTH-1:0]                 in_r,
  output logic [$clog2(N_FILTERS*N_TAPS)-1:0]   coef_addr,
  input  logic [COEFF_WIDTH-1:0]                coef_data,
  output logic [DATA_WIDTH-1:0]                 out_l,
  output logic [DATA_WIDTH-1:0]                 out_r,
  output logic                                  out_valid,
  output logic                                  busy,
  output logic [2:0]                            selected_filter,
  output logic [7:0]                            overrun_cnt
);

  localparam int unsigned ADDR_W = $clog2(N_FILTERS * N_TAPS);
  localparam int unsigned TAP_W  = $clog2(N_TAPS);
  localparam int unsigned PROD_W = DATA_WIDTH + COEFF_WIDTH;
  localparam int unsigned ACC_W  = PROD_W + $clog2(N_TAPS);
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(N_TAPS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_L = 3'd1,
    ISSUE_R = 3'd2,
    DRAIN   = 3'd3,
    OUT     = 3'd4
  } state_e;

  state_e                   state_q;
  logic [TAP_W-1:0]         tap_q;
  logic [TAP_W-1:0]         rd_idx_q;
  logic [TAP_W-1:0]         base_q;
  logic [TAP_W-1:0]         wp_q;
  logic [ADDR_W-1:0]        coef_base_q;
  logic                     drain_q;
  logic [DATA_WIDTH-1:0]    hist_l [N_TAPS];
  logic [DATA_WIDTH-1:0]    hist_r [N_TAPS];

  // Multiply-accumulate pipeline: issue -> ROM/sample align -> product -> acc
  logic                     iss_vld, iss_ch;
  logic signed [DATA_WIDTH-1:0] sample_q;
  logic                     s1_vld, s1_ch;
  logic signed [DATA_WIDTH-1:0] sample_d;
  logic                     p_vld, p_ch;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [ACC_W-1:0]  acc_l, acc_r;
  logic signed [ACC_W-1:0]  acc_l_nxt, acc_r_nxt;

  logic signed [COEFF_WIDTH-1:0] coef_s;
  logic [2:0]               sw_dec;
  logic [N_FILTERS-1:0]     onehot;
  logic                     accept;
  logic                     drop;

  assign coef_s = coef_data;
  // The cycle that shows out_valid still belongs to the finished packet.
  assign accept = new_packet && (state_q == IDLE) && !out_valid;
  assign drop   = new_packet && !accept;

  // One-hot switch decode: highest switch bit selects filter 1.
  always_comb begin
    sw_dec = 3'd0;
    onehot = '0;
    for (int i = 0; i < int'(N_FILTERS); i++) begin
      onehot    = '0;
      onehot[i] = 1'b1;
      if (sw == onehot) sw_dec = 3'(int'(N_FILTERS) - i);
    end
  end

  // Accumulator update shared by the register and the final output path.
  always_comb begin
    acc_l_nxt = acc_l;
    acc_r_nxt = acc_r;
    if (p_vld) begin
      if (p_ch) acc_r_nxt = acc_r + ACC_W'(prod_q);
      else      acc_l_nxt = acc_l + ACC_W'(prod_q);
    end
  end

  // Divide by 2^COEFF_WIDTH truncating toward zero, then clamp to DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] scale_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] mag;
    logic signed [ACC_W-1:0] q;
    mag = a[ACC_W-1] ? -a : a;
    q   = mag >>> COEFF_WIDTH;
    if (a[ACC_W-1]) q = -q;
    if ((&q[ACC_W-1:DATA_WIDTH-1]) || !(|q[ACC_W-1:DATA_WIDTH-1]))
      return q[DATA_WIDTH-1:0];
    else if (q[ACC_W-1])
      return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
  endfunction

  // Scheduler FSM, history, MAC pipeline and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      tap_q           <= '0;
      rd_idx_q        <= '0;
      base_q          <= '0;
      wp_q            <= '0;
      coef_base_q     <= '0;
      drain_q         <= 1'b0;
      iss_vld         <= 1'b0;
      iss_ch          <= 1'b0;
      sample_q        <= '0;
      s1_vld          <= 1'b0;
      s1_ch           <= 1'b0;
      sample_d        <= '0;
      p_vld           <= 1'b0;
      p_ch            <= 1'b0;
      prod_q          <= '0;
      acc_l           <= '0;
      acc_r           <= '0;
      coef_addr       <= '0;
      out_l           <= '0;
      out_r           <= '0;
      out_valid       <= 1'b0;
      busy            <= 1'b0;
      selected_filter <= 3'd0;
      overrun_cnt     <= 8'd0;
      for (int i = 0; i < int'(N_TAPS); i++) begin
        hist_l[i] <= '0;
        hist_r[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      coef_addr <= '0;
      iss_vld   <= 1'b0;
      s1_vld    <= iss_vld;
      s1_ch     <= iss_ch;
      sample_d  <= sample_q;
      p_vld     <= s1_vld;
      p_ch      <= s1_ch;
      prod_q    <= PROD_W'(coef_s) * PROD_W'(sample_d);
      acc_l     <= acc_l_nxt;
      acc_r     <= acc_r_nxt;

      if (drop && (overrun_cnt != 8'hFF)) overrun_cnt <= overrun_cnt + 8'd1;

      case (state_q)
        IDLE: begin
          if (accept) begin
            hist_l[wp_q]    <= in_l;
            hist_r[wp_q]    <= in_r;
            base_q          <= wp_q;
            rd_idx_q        <= wp_q;
            wp_q            <= (wp_q == TAP_LAST) ? '0 : wp_q + TAP_W'(1);
            selected_filter <= sw_dec;
            coef_base_q     <= (sw_dec == 3'd0) ? '0
                               : ADDR_W'((int'(sw_dec) - 1) * int'(N_TAPS));
            tap_q           <= '0;
            acc_l           <= '0;
            acc_r           <= '0;
            s1_vld          <= 1'b0;
            p_vld           <= 1'b0;
            busy            <= 1'b1;
            state_q         <= (sw_dec == 3'd0) ? OUT : ISSUE_L;
          end
        end
        ISSUE_L, ISSUE_R: begin
          coef_addr <= coef_base_q + ADDR_W'(tap_q);
          sample_q  <= (state_q == ISSUE_R) ? hist_r[rd_idx_q] : hist_l[rd_idx_q];
          iss_vld   <= 1'b1;
          iss_ch    <= (state_q == ISSUE_R);
          rd_idx_q  <= (rd_idx_q == '0) ? TAP_LAST : rd_idx_q - TAP_W'(1);
          if (tap_q == TAP_LAST) begin
            // Right channel restarts at the newest sample with no bubble.
            tap_q    <= '0;
            rd_idx_q <= base_q;
            drain_q  <= 1'b0;
            state_q  <= (state_q == ISSUE_L) ? ISSUE_R : DRAIN;
          end else begin
            tap_q <= tap_q + TAP_W'(1);
          end
        end
        DRAIN: begin
          if (drain_q) state_q <= OUT;
          else         drain_q <= 1'b1;
        end
        OUT: begin
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state_q   <= IDLE;
          if (selected_filter == 3'd0) begin
            out_l <= hist_l[base_q];
            out_r <= hist_r[base_q];
          end else begin
            // Last right product lands this cycle, so use the next-state sum.
            out_l <= scale_sat(acc_l_nxt);
            out_r <= scale_sat(acc_r_nxt);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
module tb_fir_mac_scheduler;

  localparam int N  = 45;
  localparam int NF = 4;
  localparam int LAT_FIR = 2 * N + 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sw = 4'd0;
  logic        new_packet = 1'b0;
  logic [23:0] in_l = '0, in_r = '0;
  logic [7:0]  coef_addr;
  logic [15:0] coef_data = '0;
  logic [23:0] out_l, out_r;
  logic        out_valid, busy;
  logic [2:0]  selected_filter;
  logic [7:0]  overrun_cnt;

  fir_mac_scheduler dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .new_packet(new_packet),
    .in_l(in_l), .in_r(in_r), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_l(out_l), .out_r(out_r), .out_valid(out_valid), .busy(busy),
    .selected_filter(selected_filter), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  // External coefficient ROM: one-cycle read latency.
  logic signed [15:0] rom [NF*N];
  always @(posedge clk) coef_data <= rom[coef_addr];

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural reference: history arrays, write pointer, overrun count.
  longint mh_l [N];
  longint mh_r [N];
  int     mwp;
  int     exp_ovr;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int dec(input logic [3:0] s);
    case (s)
      4'b0000: return 0;
      4'b0001: return 4;
      4'b0010: return 3;
      4'b0100: return 2;
      4'b1000: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic longint model_out(input bit right, input int f, input int base);
    longint s;
    longint smp;
    s = 0;
    if (f == 0) return right ? mh_r[base] : mh_l[base];
    for (int k = 0; k < N; k++) begin
      smp = right ? mh_r[(base - k + N) % N] : mh_l[(base - k + N) % N];
      s += longint'(rom[(f - 1) * N + k]) * smp;
    end
    s = s / 65536;
    if (s > 64'sd8388607) s = 64'sd8388607;
    if (s < -64'sd8388608) s = -64'sd8388608;
    return s;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin mh_l[i] = 0; mh_r[i] = 0; end
    mwp = 0;
    exp_ovr = 0;
  endtask

  task automatic rom_pattern();
    for (int f = 0; f < NF; f++)
      for (int k = 0; k < N; k++) rom[f * N + k] = 16'(16 * f + k + 1);
  endtask

  task automatic rom_fill(input logic [15:0] v);
    for (int i = 0; i < NF * N; i++) rom[i] = v;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_out_l"}, longint'(out_l), 0);
    chk({tag, "_out_r"}, longint'(out_r), 0);
    chk({tag, "_out_valid"}, longint'(out_valid), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_coef_addr"}, longint'(coef_addr), 0);
    chk({tag, "_sel"}, longint'(selected_filter), 0);
    chk({tag, "_ovr"}, longint'(overrun_cnt), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    new_packet = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
  endtask

  // Send one packet, optionally inject a dropped packet / switch change /
  // a packet during the out_valid cycle, then check everything the
  // reference predicts. Returns one cycle after out_valid.
  task automatic do_packet(input logic [3:0] s, input logic [23:0] l, input logic [23:0] r,
                           input int ovr_cyc, input int swc_cyc, input logic [3:0] s2,
                           input bit ovr_at_valid);
    int f, base, cyc, bad_addr, exp_lat;
    longint el, er, ea;
    sw = s; in_l = l; in_r = r; new_packet = 1'b1;
    @(posedge clk);
    f = dec(s);
    base = mwp;
    mh_l[mwp] = longint'($signed(l));
    mh_r[mwp] = longint'($signed(r));
    mwp = (mwp + 1) % N;
    exp_lat = (f == 0) ? 1 : LAT_FIR;
    el = model_out(1'b0, f, base);
    er = model_out(1'b1, f, base);
    @(negedge clk);
    new_packet = 1'b0;
    cyc = 0;
    bad_addr = 0;
    chk("busy_at_accept", longint'(busy), 1);
    chk("sel_at_accept", longint'(selected_filter), f);
    while (cyc < 200) begin
      if (cyc == ovr_cyc - 1) begin
        new_packet = 1'b1; in_l = l ^ 24'h5A5A5A; in_r = r ^ 24'hA5A5A5;
        exp_ovr = (exp_ovr < 255) ? exp_ovr + 1 : 255;
      end else new_packet = 1'b0;
      if (cyc == swc_cyc - 1) sw = s2;
      @(negedge clk);
      cyc++;
      if (f == 0 || cyc > 2 * N) ea = 0;
      else ea = (f - 1) * N + ((cyc - 1) % N);
      if (cyc <= exp_lat && longint'(coef_addr) != ea) bad_addr++;
      if (out_valid) break;
    end
    new_packet = 1'b0;
    chk("latency", cyc, exp_lat);
    chk("coef_addr_sweep_errs", bad_addr, 0);
    chk("out_l", longint'($signed(out_l)), el);
    chk("out_r", longint'($signed(out_r)), er);
    chk("busy_at_valid", longint'(busy), 0);
    if (ovr_at_valid) begin
      new_packet = 1'b1; in_l = 24'h777777; in_r = 24'h777777;
      exp_ovr = (exp_ovr < 255) ? exp_ovr + 1 : 255;
    end
    @(negedge clk);
    new_packet = 1'b0;
    chk("valid_one_pulse", longint'(out_valid), 0);
    chk("overrun_cnt", longint'(overrun_cnt), exp_ovr);
    chk("sel_held", longint'(selected_filter), f);
  endtask

  typedef struct {
    logic [3:0]  sw;
    logic [23:0] l, r;
    logic [23:0] exp_l, exp_r;
    int          exp_sel;
  } byp_vec_t;

  byp_vec_t vecs [4];

  initial begin
    logic [3:0] rs;
    int seen_valid;

    vecs[0] = '{4'b0000, 24'h123456, 24'hFFFFFB, 24'h123456, 24'hFFFFFB, 0};
    vecs[1] = '{4'b0011, 24'h000001, 24'h7FFFFF, 24'h000001, 24'h7FFFFF, 0};
    vecs[2] = '{4'b1111, 24'h800000, 24'h00ABCD, 24'h800000, 24'h00ABCD, 0};
    vecs[3] = '{4'b0101, 24'hFEDCBA, 24'h000000, 24'hFEDCBA, 24'h000000, 0};

    rom_pattern();
    model_clear();
    #1;
    check_idle_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Bypass table.
    for (int i = 0; i < 4; i++) begin
      do_packet(vecs[i].sw, vecs[i].l, vecs[i].r, -1, -1, 4'd0, 1'b0);
      chk("byp_tbl_l", longint'(out_l), longint'(vecs[i].exp_l));
      chk("byp_tbl_r", longint'(out_r), longint'(vecs[i].exp_r));
      chk("byp_tbl_sel", longint'(selected_filter), vecs[i].exp_sel);
    end

    // Impulse through filter 1 from cleared history.
    do_reset();
    for (int p = 0; p <= N; p++) begin
      do_packet(4'b1000, (p == 0) ? 24'h010000 : 24'h0, 24'h0, -1, -1, 4'd0, 1'b0);
      chk("impulse_l", longint'($signed(out_l)), (p < N) ? p + 1 : 0);
      chk("impulse_r", longint'($signed(out_r)), 0);
    end

    // Saturation positive then negative.
    do_reset();
    rom_fill(16'h7FFF);
    for (int p = 0; p <= N; p++) do_packet(4'b1000, 24'h7FFFFF, 24'h7FFFFF, -1, -1, 4'd0, 1'b0);
    chk("sat_pos", longint'(out_l), longint'(24'h7FFFFF));
    for (int p = 0; p <= N; p++) do_packet(4'b1000, 24'h800000, 24'h800000, -1, -1, 4'd0, 1'b0);
    chk("sat_neg", longint'(out_l), longint'(24'h800000));

    // Truncation toward zero: only tap 0 of filter 1 is -1 LSB.
    do_reset();
    rom_fill(16'h0000);
    rom[0] = 16'hFFFF;
    do_packet(4'b1000, 24'h000001, 24'h000001, -1, -1, 4'd0, 1'b0);
    chk("trunc_small_neg", longint'($signed(out_l)), 0);
    do_packet(4'b1000, 24'hFF0000, 24'hFF0000, -1, -1, 4'd0, 1'b0);
    chk("trunc_pos_one", longint'($signed(out_l)), 1);

    // Overrun and select latch.
    do_reset();
    rom_pattern();
    do_packet(4'b1000, 24'h012345, 24'hFEDCBA, 10, 20, 4'b0001, 1'b0);
    chk("ovr_count_1", longint'(overrun_cnt), 1);
    do_packet(4'b0001, 24'h000100, 24'h000200, -1, -1, 4'd0, 1'b0);
    chk("next_uses_f4", longint'(selected_filter), 4);
    do_packet(4'b0000, 24'h00AAAA, 24'h005555, -1, -1, 4'd0, 1'b1);
    chk("ovr_at_valid", longint'(overrun_cnt), 2);

    // Randomized traffic against the reference model.
    do_reset();
    for (int p = 0; p < 60; p++) begin
      case ($urandom_range(0, 5))
        0: rs = 4'b0000;
        1: rs = 4'b0001;
        2: rs = 4'b0010;
        3: rs = 4'b0100;
        4: rs = 4'b1000;
        default: rs = 4'($urandom);
      endcase
      do_packet(rs, 24'($urandom), 24'($urandom),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 60)) : -1,
                -1, 4'd0, 1'b0);
    end

    // Reset in the middle of a computation.
    @(negedge clk);
    sw = 4'b1000; in_l = 24'h123456; in_r = 24'h654321; new_packet = 1'b1;
    @(negedge clk);
    new_packet = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_zero("midop_reset");
    seen_valid = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    chk("midop_no_valid", seen_valid, 0);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    for (int p = 0; p < 5; p++) begin
      do_packet(4'b1000, (p == 0) ? 24'h010000 : 24'h0, 24'h0, -1, -1, 4'd0, 1'b0);
      chk("post_reset_impulse", longint'($signed(out_l)), p + 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_mac_scheduler.md
Name: fir_mac_scheduler

Overview:
Time-multiplexed dual-channel FIR controller. It shares one registered multiplier and one accumulator per channel across all taps and both channels, instead of a fully parallel MAC tree. On each audio packet it stores the new L/R samples in an internal circular history and latches the filter selection. It then sequences coefficient-ROM addresses and sample reads through the shared multiplier, and presents scaled, saturated L/R outputs with a valid pulse. It sits between the audio receive interface and the transmit interface, with the coefficient ROM external.

Parameters:
DATA_WIDTH, 24, sample width (signed two's complement)
COEFF_WIDTH, 16, coefficient width (signed, Q1.15)
N_TAPS, 45, taps per filter
N_FILTERS, 4, number of filters stored in the coefficient ROM

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sw  in  N_FILTERS  filter-select switches
new_packet  in  1  one-cycle strobe; in_l and in_r are valid
in_l  in  DATA_WIDTH  left input sample
in_r  in  DATA_WIDTH  right input sample
coef_addr  out  $clog2(N_FILTERS*N_TAPS)  coefficient ROM address
coef_data  in  COEFF_WIDTH  ROM data; arrives 1 cycle after coef_addr
out_l  out  DATA_WIDTH  filtered left sample
out_r  out  DATA_WIDTH  filtered right sample
out_valid  out  1  one-cycle pulse; out_l and out_r are updated
busy  out  1  high from packet accept until out_valid
selected_filter  out  3  filter latched for the current or last packet (0 = bypass)
overrun_cnt  out  8  saturating count of dropped packets

Behaviour:
- Reset: one clock domain, asynchronous active-low reset rst_n. While rst_n is low, all of the following are 0:
  - outputs, coef_addr, overrun_cnt
  - sample history, both accumulators, write pointer wp
  - state = IDLE
- Reset mid-operation: aborts the computation immediately; no out_valid is produced.
- Switch decode, sampled only at packet accept:
  - 0000 -> 0, 0001 -> 4, 0010 -> 3, 0100 -> 2, 1000 -> 1
  - any other pattern -> 0
  - sw changes while busy have no effect on the packet in progress.
- States: IDLE, ISSUE_L, ISSUE_R, DRAIN, OUT.
- Accept (cycle 0): new_packet is sampled in IDLE.
  - in_l and in_r are written at history[wp].
  - The tap base pointer is latched as wp; wp then increments mod N_TAPS.
  - selected_filter is latched.
- Bypass (selected_filter = 0):
  - out_l = in_l and out_r = in_r; out_valid pulses in cycle 1.
  - busy is high in cycle 0 only.
  - coef_addr stays at 0.
- Filter f = 1..N_FILTERS:
  - ISSUE_L, cycles 1..N_TAPS: for k = 0..N_TAPS-1,
    - coef_addr = (f-1)*N_TAPS + k
    - sample = history_l[(base - k) mod N_TAPS], so k = 0 is the newest sample.
  - ISSUE_R, cycles N_TAPS+1..2*N_TAPS: same sequence on the right history.
  - Pipeline per tap: issue at cycle c; product coef_data*sample registered at the end of c+1; accumulated at c+2.
  - The accumulators are cleared at accept, and there are no bubbles between channels.
  - DRAIN covers the last two pipeline stages.
  - OUT: out_l and out_r update and out_valid pulses in cycle 2*N_TAPS+3 (cycle 93 for the defaults). busy drops in the same cycle.
- Arithmetic:
  - Accumulator width = DATA_WIDTH + COEFF_WIDTH + $clog2(N_TAPS), full precision.
  - Scaling: divide by 2^COEFF_WIDTH, truncating toward zero. Negative results are negated, shifted, then negated back.
  - Saturation: results are clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Overrun: new_packet while busy (including the cycle out_valid is high) is dropped.
  - overrun_cnt increments and saturates at 255.
  - The history and the result in progress are unaffected.
- History wrap: after N_TAPS packets, the oldest sample is overwritten. The history also fills during bypass, so switching filters uses valid past samples.

Test Plan:
1. Bypass: sw=0000, in_l=24'h123456, in_r=-5 -> cycle 1: out_l=24'h123456, out_r=-5, out_valid for 1 cycle; coef_addr stays 0.
2. Impulse, using a ROM model with coeff[f][k]=16*f+k+1:
   - Stimulus: sw=1000, in_l=24'h010000 on packet 0, then zeros; in_r=0 throughout.
   - Required: packet p gives out_l=p+1 for p<45 and 0 at p=45; out_r=0.
   - Required: out_valid at cycle 93 after each accept; coef_addr sweeps 0..44 twice per packet.
3. Saturation: all coefficients 16'h7FFF, 45+ packets of 24'h7FFFFF -> out_l=24'h7FFFFF; same with 24'h800000 -> out_l=24'h800000.
4. Truncation toward zero: only tap 0 = 16'hFFFF, input 1 -> product -1, out_l=0 (not -1); input -65536 -> out_l=1.
5. Overrun and select latch:
   - Stimulus: second new_packet at cycle 10; sw toggled to 0001 at cycle 20.
   - Required: overrun_cnt=1; result equals the single-packet filter-1 output; the next packet uses filter 4.
6. Reset mid-op: rst_n low at cycle 40 -> all outputs 0 asynchronously, no out_valid; a subsequent impulse run matches scenario 2 from a cleared history.
